// File: rtl/fp_pkg.sv
// Shared constants and bundles for the FMA rounding stage.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int SIG_W  = 27;
  localparam int FRAC_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef struct packed {
    logic [SIG_W-1:0] sig;
    logic [EXP_W-1:0] exp;
  } rnd_req_t;

  typedef struct packed {
    logic [FRAC_W-1:0] frac;
    logic [EXP_W-1:0]  exp;
    logic              ovf;
  } rnd_res_t;

endpackage

// File: rtl/rne_core.sv
// Round-to-nearest-even of a 24+GRS significand with exponent carry.
module rne_core
  import fp_pkg::FRAC_W;
#(
  parameter int EXP_W = 8,
  parameter int SIG_W = 27
) (
  input  logic [SIG_W-1:0]  sig,
  input  logic [EXP_W-1:0]  exp,
  output logic [FRAC_W-1:0] frac,
  output logic [EXP_W-1:0]  rexp,
  output logic              ovf
);

  logic [24:0] t;
  logic [2:0]  grs;
  logic        inc;
  logic        carry;
  logic        special;

  assign grs = sig[2:0];
  assign inc = (grs > 3'b100) ||
               ((grs == 3'b100) && sig[3]);
  assign t = {1'b0, sig[SIG_W-1:3]} + 25'(inc);
  assign carry = t[24];
  assign special = (exp == {EXP_W{1'b1}});

  always_comb begin
    frac = carry ? t[23:1] : t[22:0];
    rexp = exp + EXP_W'(carry);
    ovf  = carry &&
           (exp == {{(EXP_W-1){1'b1}}, 1'b0});
    if (ovf)
      frac = '0;
    // NaN/Inf inputs are forwarded untouched
    if (special) begin
      frac = sig[SIG_W-2:3];
      rexp = exp;
      ovf  = 1'b0;
    end
  end

endmodule

// File: rtl/round_arb.sv
// Round-robin arbiter + RNE rounding stage with registered output.
// Optional transfer counters: define RND_ARB_CNT_EN.
module round_arb #(
  parameter int EXP_W = 8,
  parameter int SIG_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [SIG_W-1:0] a_sig,
  input  logic [EXP_W-1:0] a_exp,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [SIG_W-1:0] b_sig,
  input  logic [EXP_W-1:0] b_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [22:0]      out_frac,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_ovf,
`ifdef RND_ARB_CNT_EN
  output logic [15:0]      cnt_a,
  output logic [15:0]      cnt_b,
`endif
  output logic             out_src
);

  typedef enum logic {EMPTY, FULL} ost_t;

  ost_t st, st_nx;
  logic lg;
  logic can_acc, ga, gb, xfer;
  logic [SIG_W-1:0] m_sig;
  logic [EXP_W-1:0] m_exp;
  logic [22:0]      r_frac;
  logic [EXP_W-1:0] r_exp;
  logic             r_ovf;

  assign out_valid = (st == FULL);
  assign can_acc = !out_valid || out_ready;
  assign gb = b_valid && (!a_valid || !lg);
  assign ga = a_valid && !gb;
  assign a_ready = !rst && can_acc && ga;
  assign b_ready = !rst && can_acc && gb;
  assign xfer = a_ready || b_ready;

  assign m_sig = gb ? b_sig : a_sig;
  assign m_exp = gb ? b_exp : a_exp;

  rne_core #(
    .EXP_W(EXP_W),
    .SIG_W(SIG_W)
  ) u_rne (
    .sig (m_sig),
    .exp (m_exp),
    .frac(r_frac),
    .rexp(r_exp),
    .ovf (r_ovf)
  );

  always_comb begin
    st_nx = st;
    unique case (st)
      EMPTY: if (xfer) st_nx = FULL;
      FULL:  if (out_ready && !xfer) st_nx = EMPTY;
      default: st_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= EMPTY;
      lg       <= 1'b1;
      out_frac <= '0;
      out_exp  <= '0;
      out_ovf  <= 1'b0;
      out_src  <= 1'b0;
    end else begin
      st <= st_nx;
      if (xfer) begin
        lg       <= b_ready;
        out_frac <= r_frac;
        out_exp  <= r_exp;
        out_ovf  <= r_ovf;
        out_src  <= b_ready;
      end
    end
  end

`ifdef RND_ARB_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (a_ready && cnt_a != 16'hFFFF)
        cnt_a <= cnt_a + 16'd1;
      if (b_ready && cnt_b != 16'hFFFF)
        cnt_b <= cnt_b + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_round_arb.sv
// Randomised + directed bench for round_arb against a behavioural model.
module tb_round_arb;

  logic        clk = 0;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [26:0] a_sig, b_sig;
  logic [7:0]  a_exp, b_exp;
  logic        out_valid, out_ready;
  logic [22:0] out_frac;
  logic [7:0]  out_exp;
  logic        out_ovf, out_src;
`ifdef RND_ARB_CNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  int tests = 0;
  int fails = 0;

  // model state
  logic        m_v = 0;
  logic        m_lg = 1;
  logic [22:0] m_frac = 0;
  logic [7:0]  m_exp = 0;
  logic        m_ovf = 0;
  logic        m_src = 0;
  int          m_ca = 0;
  int          m_cb = 0;
  logic        last_a, last_b;

  always #5 clk = ~clk;

  round_arb dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_sig(a_sig), .a_exp(a_exp),
    .b_valid(b_valid), .b_ready(b_ready),
    .b_sig(b_sig), .b_exp(b_exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_frac(out_frac), .out_exp(out_exp),
    .out_ovf(out_ovf),
`ifdef RND_ARB_CNT_EN
    .cnt_a(cnt_a), .cnt_b(cnt_b),
`endif
    .out_src(out_src)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // numeric RNE on the significand value
  task automatic mround(input logic [26:0] s,
                        input logic [7:0] e,
                        output logic [22:0] f,
                        output logic [7:0] oe,
                        output logic ov);
    int unsigned m, rem;
    m = 32'(s) / 8;
    rem = 32'(s) % 8;
    if (e == 8'd255) begin
      f = s[25:3];
      oe = e;
      ov = 0;
      return;
    end
    if (rem > 4 || (rem == 4 && m % 2 == 1))
      m = m + 1;
    oe = e;
    if (m >= 32'h100_0000) begin
      m = m / 2;
      oe = e + 8'd1;
    end
    ov = (oe == 8'd255);
    f = ov ? 23'd0 : 23'(m % 32'h80_0000);
  endtask

  task automatic step(input logic av,
                      input logic [26:0] as,
                      input logic [7:0] ae,
                      input logic bv,
                      input logic [26:0] bs,
                      input logic [7:0] be,
                      input logic ordy,
                      input logic r);
    logic can, pb, pa, ea, eb;
    logic [22:0] f;
    logic [7:0] oe;
    logic ov;
    a_valid = av; a_sig = as; a_exp = ae;
    b_valid = bv; b_sig = bs; b_exp = be;
    out_ready = ordy; rst = r;
    #1;
    can = !m_v || ordy;
    // round robin: B wins a tie only if A went last
    pb = bv && (!av || !m_lg);
    pa = av && !pb;
    ea = !r && can && pa;
    eb = !r && can && pb;
    chk("a_ready", 32'(a_ready), 32'(ea));
    chk("b_ready", 32'(b_ready), 32'(eb));
    chk("out_valid", 32'(out_valid), 32'(m_v));
    if (m_v) begin
      chk("out_frac", 32'(out_frac), 32'(m_frac));
      chk("out_exp", 32'(out_exp), 32'(m_exp));
      chk("out_ovf", 32'(out_ovf), 32'(m_ovf));
      chk("out_src", 32'(out_src), 32'(m_src));
    end
    @(posedge clk);
    if (r) begin
      m_v = 0; m_lg = 1; m_ca = 0; m_cb = 0;
    end else if (ea || eb) begin
      if (eb) mround(bs, be, f, oe, ov);
      else    mround(as, ae, f, oe, ov);
      m_frac = f; m_exp = oe; m_ovf = ov;
      m_src = eb; m_lg = eb; m_v = 1;
      if (ea && m_ca < 65535) m_ca++;
      if (eb && m_cb < 65535) m_cb++;
    end else if (ordy) begin
      m_v = 0;
    end
    last_a = ea;
    last_b = eb;
    #1;
  endtask

  function automatic logic [26:0] rsig();
    logic [26:0] s;
    s = 27'($urandom);
    case ($urandom_range(0, 5))
      0: s[2:0] = 3'b100;
      1: s = 27'h7FF_FFFF;
      default: ;
    endcase
    s[26] = 1'b1;
    return s;
  endfunction

  function automatic logic [7:0] rexp();
    case ($urandom_range(0, 5))
      0: return 8'hFE;
      1: return 8'hFF;
      2: return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  logic        pa_v, pb_v;
  logic [26:0] pa_s, pb_s;
  logic [7:0]  pa_e, pb_e;
  logic [22:0] hold_f;
  logic [7:0]  hold_e;

  initial begin
    a_valid = 0; b_valid = 0; out_ready = 0;
    a_sig = 0; b_sig = 0; a_exp = 0; b_exp = 0;
    rst = 1;
    #1;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_frac", 32'(out_frac), 0);
    chk("rst_exp", 32'(out_exp), 0);
    chk("rst_src", 32'({out_ovf, out_src}), 0);

    // tie, even LSB
    step(1, 27'h400_0004, 8'h7F, 0, 0, 0, 1, 0);
    chk("tie_even_frac", 32'(out_frac), 32'h0);
    chk("tie_even_exp", 32'(out_exp), 32'h7F);
    chk("tie_even_src", 32'(out_src), 0);
    // tie, odd LSB
    step(0, 0, 0, 1, 27'h400_000C, 8'h10, 1, 0);
    chk("tie_odd_frac", 32'(out_frac), 32'h2);
    chk("tie_odd_exp", 32'(out_exp), 32'h10);
    chk("tie_odd_src", 32'(out_src), 1);
    // significand carry
    step(1, 27'h7FF_FFFF, 8'h7F, 0, 0, 0, 1, 0);
    chk("carry_frac", 32'(out_frac), 0);
    chk("carry_exp", 32'(out_exp), 32'h80);
    chk("carry_ovf", 32'(out_ovf), 0);
    step(1, 27'h7FF_FFFF, 8'hFE, 0, 0, 0, 1, 0);
    chk("ovf_frac", 32'(out_frac), 0);
    chk("ovf_exp", 32'(out_exp), 32'hFF);
    chk("ovf_flag", 32'(out_ovf), 1);
    // NaN passthrough
    step(1, 27'h7FF_FFFF, 8'hFF, 0, 0, 0, 1, 0);
    chk("nan_frac", 32'(out_frac), 32'h7F_FFFF);
    chk("nan_ovf", 32'(out_ovf), 0);

    // alternation after reset
    step(0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) begin
      step(1, rsig(), 8'h40, 1, rsig(), 8'h41, 1, 0);
      chk("alt_a", 32'(last_a), 32'(i % 2 == 0));
      chk("alt_b", 32'(last_b), 32'(i % 2 == 1));
    end

    // backpressure then drain+reload
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 27'h400_0008, 8'h20, 0, 0, 0, 1, 0);
    hold_f = out_frac;
    hold_e = out_exp;
    for (int i = 0; i < 3; i++) begin
      step(1, 27'h500_0000, 8'h21, 0, 0, 0, 0, 0);
      chk("bp_ready", 32'(last_a), 0);
      chk("bp_frac", 32'(out_frac), 32'(hold_f));
      chk("bp_exp", 32'(out_exp), 32'(hold_e));
    end
    step(1, 27'h500_0000, 8'h21, 0, 0, 0, 1, 0);
    chk("reload_ready", 32'(last_a), 1);
    chk("reload_valid", 32'(out_valid), 1);
    chk("reload_exp", 32'(out_exp), 32'h21);

    // reset while full
    step(1, 27'h400_0000, 8'h30, 0, 0, 0, 0, 0);
    step(1, 27'h400_0000, 8'h30, 0, 0, 0, 1, 1);
    chk("rst_mid_ready", 32'(last_a), 0);
    chk("rst_mid_valid", 32'(out_valid), 0);
    step(1, rsig(), 8'h30, 1, rsig(), 8'h31, 1, 0);
    chk("rst_mid_lg", 32'(last_a), 1);

    // random traffic with stable-until-accepted requesters
    pa_v = 0; pb_v = 0;
    pa_s = 0; pb_s = 0; pa_e = 0; pb_e = 0;
    for (int i = 0; i < 3000; i++) begin
      logic rr;
      if (!pa_v && $urandom_range(0, 2) != 0) begin
        pa_v = 1; pa_s = rsig(); pa_e = rexp();
      end
      if (!pb_v && $urandom_range(0, 2) != 0) begin
        pb_v = 1; pb_s = rsig(); pb_e = rexp();
      end
      rr = ($urandom_range(0, 199) == 0);
      step(pa_v, pa_s, pa_e, pb_v, pb_s, pb_e,
           $urandom_range(0, 3) != 0, rr);
      if (last_a) pa_v = 0;
      if (last_b) pb_v = 0;
    end

`ifdef RND_ARB_CNT_EN
    step(0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 70000; i++)
      step(1, 27'h400_0000, 8'h01, 0, 0, 0, 1, 0);
    chk("cnt_a_sat", 32'(cnt_a), 32'hFFFF);
    chk("cnt_a_model", 32'(cnt_a), 32'(m_ca));
    chk("cnt_b", 32'(cnt_b), 32'(m_cb));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
